// File: rtl/excess3_to_bcd_seq.sv
// Multi-digit Excess-3 to BCD converter, one digit per clock, LSD first, valid/ready on both sides.
// Optional invalid-code detection is enabled by defining E3_ERR_DETECT_EN.
module excess3_to_bcd_seq #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_err,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(DIGITS) + 1;
  localparam int unsigned DW    = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [DW-1:0]    word, word_nxt;
  logic [DW-1:0]    bcd_nxt;
  logic             err_nxt;
  logic [3:0]       code_c;
  logic [3:0]       digit_c;
`ifdef E3_ERR_DETECT_EN
  logic             digit_bad_c;
`endif

  // Select the captured digit addressed by the counter
  always_comb begin
    code_c = 4'h0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (cnt == CNT_W'(i)) code_c = word[4*i +: 4];
    end
  end

  // Single-digit Excess-3 decode
  always_comb begin
    digit_c = code_c - 4'd3;
`ifdef E3_ERR_DETECT_EN
    digit_bad_c = (code_c < 4'd3) || (code_c > 4'd12);
    if (digit_bad_c) digit_c = 4'hF;
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    word_nxt  = word;
    bcd_nxt   = out_bcd;
    err_nxt   = out_err;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          word_nxt  = in_data;
          err_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = CONV;
        end
      end
      CONV: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (cnt == CNT_W'(i)) bcd_nxt[4*i +: 4] = digit_c;
        end
`ifdef E3_ERR_DETECT_EN
        if (digit_bad_c) err_nxt = 1'b1;
`endif
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DIGITS - 1)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Handshake flags are registered copies of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      word      <= '0;
      out_bcd   <= '0;
      out_err   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      word      <= word_nxt;
      out_bcd   <= bcd_nxt;
      out_err   <= err_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt == CONV);
    end
  end

endmodule
